mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single byte-wide unified RAM port between instruction fetch and the MEM stage. It serialises 8-bit RAM beats into 32-bit fetches and 1/2/4-byte data accesses. It raises the IF and MEM stall requests consumed by the pipeline stall controller while a requester is waiting. MEM has priority; a transfer in progress is never preempted.

## Interface
- No parameters; addresses are 32-bit, the RAM port is 8-bit.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request (level); held until if_done.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word, little-endian; valid when if_done=1.
- if_done  out  1  one-cycle completion pulse for a fetch.
- mem_req  in  1  data request (level); held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  transfer size: 0 = 1 byte, 1 = 2 bytes, 3 = 4 bytes; 2 is reserved and treated as 4.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  store data; byte i is written to mem_addr+i.
- mem_rdata  out  32  load data, zero-extended; valid when mem_done=1.
- mem_done  out  1  one-cycle completion pulse for a data access.
- ram_addr  out  32  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_dout  out  8  RAM write data.
- ram_din  in  8  RAM read data; valid the cycle after its address is driven.
- stallreq_from_if  out  1  IF stage must stall.
- stallreq_from_mem  out  1  MEM stage must stall.

## Operation
- FSM states:
  - IDLE: RAM port idle.
  - IF_XFER: serving a fetch; N = 4.
  - MEM_XFER: serving a data access; N = mem_len+1, with reserved 2 treated as 4.
  - DONE: one-cycle completion.
- IDLE transitions:
  - mem_req=1 → MEM_XFER. Latch addr, we, N and wdata; clear the byte counter.
  - else if if_req=1 → IF_XFER. Latch if_addr.
  - else stay in IDLE.
- XFER, per cycle:
  - Drive ram_addr = base+cnt while cnt < N, with ram_wr = we (always 0 for IF).
  - For a write, ram_dout = wdata[8*cnt+7:8*cnt].
  - For a read, the byte on ram_din is captured into buffer lane cnt-1 in each cycle with 1 ≤ cnt ≤ N.
  - Exit to DONE after cnt = N-1 for writes, or after cnt = N for reads.
- DONE: pulse the owner's done signal and present the registered rdata, then return to IDLE.
- Address arithmetic is base+cnt mod 2^32; wrap-around is allowed.
- Unused rdata bytes are 0.
- If the requester drops req mid-transfer, the transfer still completes and done still pulses.
- A mem_req arriving during IF_XFER waits until the fetch's DONE. The fetch is not aborted.
- The IDLE cycle after DONE always re-arbitrates, so one idle bus cycle separates back-to-back transfers.
- Stall requests are combinational:
  - stallreq_from_mem = mem_req & ~mem_done.
  - stallreq_from_if = if_req & ~if_done.

## Timing
- Reset, asynchronous and effective immediately, including mid-transfer:
  - state returns to IDLE;
  - ram_addr, ram_dout, ram_wr, if_done, mem_done, if_rdata and mem_rdata go to 0;
  - an interrupted transfer is discarded and never signals done.
- Bus outputs in IDLE/DONE: ram_wr=0, ram_addr=0, ram_dout=0.
- Latency, with the request first seen in IDLE at cycle t:
  - read of N bytes: addresses driven t+1..t+N, done at t+N+2 (fetch: t+6);
  - write of N bytes: ram_wr high t+1..t+N, done at t+N+1.
- done and rdata are registered, high for exactly one cycle.
- Simultaneous if_req and mem_req in IDLE: MEM is granted, and stallreq_from_if remains high throughout.

## Structure
- Shared package (e.g. core_pkg):
  - state enum {IDLE, IF_XFER, MEM_XFER, DONE};
  - mem_len encodings LEN_B=0, LEN_H=1, LEN_W=3;
  - RAM data width 8.
- No sub-module. The FSM, byte counter and byte-lane assembler stay in one module, roughly 150–250 lines.

## Test plan
- Fetch alone, at cycle t:
  - Stimulus: if_req at if_addr=0x100, RAM bytes 0x100..0x103 = 11 22 33 44.
  - Response: ram_addr 0x100..0x103 on t+1..t+4; if_done at t+6 with if_rdata=0x44332211; stallreq_from_if high t..t+5, low at t+6.
- Simultaneous requests:
  - Stimulus: if_req and mem_req (load, len=3, 0x200) asserted together.
  - Response: MEM is served first, mem_done at t+6; fetch addresses start at t+8; if_done at t+13.
- Halfword store:
  - Stimulus: mem_we=1, len=1, mem_addr=0x3FE, mem_wdata=0xAABBCCDD.
  - Response: ram_wr high for 2 cycles, writing DD→0x3FE then CC→0x3FF; mem_done at t+3.
- Byte load:
  - Stimulus: len=0, byte 0x80 at 0x10.
  - Response: mem_rdata=0x00000080 (zero-extended); mem_done at t+3.
- MEM request during a fetch:
  - Stimulus: mem_req asserted at t+2 of a fetch.
  - Response: the fetch completes, with if_done at t+6; MEM is granted in the IDLE cycle t+7.
- Reset mid-transfer:
  - Stimulus: rst_n low at t+3 of a fetch.
  - Response: ram_addr=0 and ram_wr=0 immediately; no if_done pulse; after release, a held if_req restarts the fetch from byte 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified RAM port arbiter.
// Byte-serial RAM, 32-bit addresses.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_XFER,
        MEM_XFER,
        DONE
    } state_t;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    localparam int RAM_DW = 8;

    // Reserved length code 2 is served as a full word.
    function automatic logic [2:0] beats(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between IF and MEM.
// MEM wins ties; a running transfer always finishes.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [31:0]       ram_addr,
    output logic              ram_wr,
    output logic [RAM_DW-1:0] ram_dout,
    input  logic [RAM_DW-1:0] ram_din,
    output logic              stallreq_from_if,
    output logic              stallreq_from_mem
);

    state_t      state;
    logic [31:0] base;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  cnt;
    logic [2:0]  n;
    logic [31:0] rbuf;

    logic [2:0]  cnt_nx;
    logic [1:0]  lane;
    logic [31:0] rbuf_nx;
    logic [31:0] nx_addr;
    logic [7:0]  nx_byte;
    logic        last;

    assign stallreq_from_mem = mem_req & ~mem_done;
    assign stallreq_from_if  = if_req & ~if_done;

    // Read data trails its address by one cycle, hence lane cnt-1.
    always_comb begin
        cnt_nx  = cnt + 3'd1;
        lane    = 2'(cnt - 3'd1);
        rbuf_nx = rbuf;
        if (!we && cnt != 3'd0)
            rbuf_nx[{lane, 3'b000} +: 8] = ram_din;
        nx_addr = base + 32'(cnt_nx);
        nx_byte = wdata[{cnt_nx[1:0], 3'b000} +: 8];
        last    = we ? (cnt == n - 3'd1) : (cnt == n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            cnt       <= '0;
            n         <= '0;
            rbuf      <= '0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_req) begin
                        state    <= MEM_XFER;
                        base     <= mem_addr;
                        we       <= mem_we;
                        n        <= beats(mem_len);
                        wdata    <= mem_wdata;
                        cnt      <= '0;
                        rbuf     <= '0;
                        ram_addr <= mem_addr;
                        ram_wr   <= mem_we;
                        ram_dout <= mem_we ? mem_wdata[7:0] : 8'h00;
                    end else if (if_req) begin
                        state    <= IF_XFER;
                        base     <= if_addr;
                        we       <= 1'b0;
                        n        <= 3'd4;
                        wdata    <= '0;
                        cnt      <= '0;
                        rbuf     <= '0;
                        ram_addr <= if_addr;
                        ram_wr   <= 1'b0;
                        ram_dout <= '0;
                    end
                end
                IF_XFER, MEM_XFER: begin
                    rbuf <= rbuf_nx;
                    cnt  <= cnt_nx;
                    if (last) begin
                        state    <= DONE;
                        ram_addr <= '0;
                        ram_wr   <= 1'b0;
                        ram_dout <= '0;
                        if (state == IF_XFER) begin
                            if_done  <= 1'b1;
                            if_rdata <= rbuf_nx;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= rbuf_nx;
                        end
                    end else if (cnt_nx < n) begin
                        ram_addr <= nx_addr;
                        ram_wr   <= we;
                        ram_dout <= we ? nx_byte : 8'h00;
                    end else begin
                        ram_addr <= '0;
                        ram_wr   <= 1'b0;
                        ram_dout <= '0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
